// File: rtl/btn_pkg.sv
// Shared types for the button group controller.
// Also used by switch_led_groups and its bench.
package btn_pkg;

  localparam int N_BTN_DEFAULT = 4;

  typedef logic [N_BTN_DEFAULT-1:0] grp_mask_t;

  // clr wins over a press landing in the same cycle
  function automatic logic next_off(
    input logic off,
    input logic press,
    input logic clr
  );
    logic nxt;
    nxt = off;
    if (clr)
      nxt = 1'b0;
    else if (press)
      nxt = ~off;
    return nxt;
  endfunction

endpackage

// File: rtl/btn_group_ctrl_debounce_ch.sv
// One button channel: synchronizer, debounce counter,
// debounced level and registered rising-edge pulse.
module debounce_ch #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // two-stage synchronizer for the asynchronous pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // qualify a new level; any return to the old level restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        cnt   <= '0;
        level <= s2;
        press <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_group_ctrl.sv
// Debounced buttons plus per-group toggle latches
// feeding the LED group gating logic.
module btn_group_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEFAULT,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] group_off
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // toggle each group on its press, clear all on clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      group_off <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++)
        group_off[i] <= next_off(group_off[i],
                                 btn_press[i], clr);
    end
  end

endmodule

// File: tb/tb_btn_group_ctrl.sv
// Scoreboard bench for btn_group_ctrl.
// Press events are queued by stimulus, popped by the monitor.
module tb_btn_group_ctrl;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic          clr;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] group_off;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] level;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  btn_group_ctrl #(
    .N_BTN    (NB),
    .DB_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .clr      (clr),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .group_off(group_off)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // monitor: pulse shape, latch behaviour, queued presses
  logic [3:0] p_press, p_goff, exp_g;
  logic       p_clr;
  bit         have_prev = 0;
  ev_t        e;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 0;
    end else begin
      if (have_prev) begin
        checks++;
        if ((p_press & btn_press) != 0) begin
          errors++;
          $display("FAIL double_press cyc=%0d got=%b prev=%b",
                   cyc, btn_press, p_press);
        end
        checks++;
        exp_g = p_clr ? 4'b0 : (p_goff ^ p_press);
        if (group_off !== exp_g) begin
          errors++;
          $display("FAIL goff_model cyc=%0d got=%b exp=%b",
                   cyc, group_off, exp_g);
        end
      end
      if (btn_press != 0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_press cyc=%0d got=%b exp=none",
                   cyc, btn_press);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.press !== btn_press ||
              e.level !== btn_level) begin
            errors++;
            $display("FAIL press_event got cyc=%0d p=%b l=%b exp cyc=%0d p=%b l=%b",
                     cyc, btn_press, btn_level,
                     e.cyc, e.press, e.level);
          end
        end
      end
      p_press   = btn_press;
      p_goff    = group_off;
      p_clr     = clr;
      have_prev = 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int c, input logic [3:0] p,
                      input logic [3:0] l);
    ev_t x;
    x.cyc   = c;
    x.press = p;
    x.level = l;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 4'hF;
    clr     = 1'b0;
    tick(3);
    chk("rst_level", btn_level, 4'h0);
    chk("rst_press", btn_press, 4'h0);
    chk("rst_goff", group_off, 4'h0);

    // 1: release reset with all buttons held
    rst = 1'b0;
    push(cyc + 6, 4'hF, 4'hF);
    tick(8);
    chk("t1_level", btn_level, 4'hF);
    chk("t1_goff", group_off, 4'hF);
    btn_raw = 4'h0;
    tick(10);
    chk("t1_release", btn_level, 4'h0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t1_clr", group_off, 4'h0);

    // 2: 3-cycle glitch is rejected
    btn_raw = 4'b0001;
    tick(3);
    btn_raw = 4'b0000;
    tick(10);
    chk("t2_level", btn_level, 4'h0);
    chk("t2_goff", group_off, 4'h0);

    // 3: bounce then hold
    btn_raw = 4'b0010; tick(1);
    btn_raw = 4'b0000; tick(1);
    btn_raw = 4'b0010; tick(1);
    btn_raw = 4'b0000; tick(1);
    btn_raw = 4'b0010;
    push(cyc + 6, 4'b0010, 4'b0010);
    tick(8);
    chk("t3_goff", group_off, 4'b0010);
    btn_raw = 4'b0000;
    tick(10);

    // 4: long hold, release, press again
    btn_raw = 4'b0100;
    push(cyc + 6, 4'b0100, 4'b0100);
    tick(50);
    chk("t4_hold_goff", group_off, 4'b0110);
    btn_raw = 4'b0000;
    tick(10);
    chk("t4_rel_level", btn_level, 4'b0000);
    chk("t4_rel_goff", group_off, 4'b0110);
    btn_raw = 4'b0100;
    push(cyc + 6, 4'b0100, 4'b0100);
    tick(8);
    chk("t4_repress_goff", group_off, 4'b0010);
    btn_raw = 4'b0000;
    tick(10);

    // 5: clr coincident with a press
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t5_clr0", group_off, 4'b0000);
    btn_raw = 4'b0101;
    push(cyc + 6, 4'b0101, 4'b0101);
    tick(8);
    chk("t5_pre_goff", group_off, 4'b0101);
    btn_raw = 4'b0000;
    tick(10);
    btn_raw = 4'b1000;
    push(cyc + 6, 4'b1000, 4'b1000);
    tick(6);
    chk("t5_press_now", btn_press, 4'b1000);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t5_clr_prio", group_off, 4'b0000);
    btn_raw = 4'b0000;
    tick(10);

    // 6: reset during qualification
    btn_raw = 4'b0001;
    tick(4);
    rst = 1'b1;
    #1;
    chk("t6_rst_level", btn_level, 4'h0);
    chk("t6_rst_press", btn_press, 4'h0);
    tick(2);
    rst = 1'b0;
    push(cyc + 6, 4'b0001, 4'b0001);
    tick(5);
    chk("t6_no_early", btn_level, 4'b0000);
    tick(3);
    chk("t6_level", btn_level, 4'b0001);
    chk("t6_goff", group_off, 4'b0001);

    tick(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_press left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
